// File: rtl/ibex_pmp_csr_regs_pkg.sv
// PMP CSR types, address map and the WARL helpers shared by the PMP CSR register file.
package ibex_pmp_csr_regs_pkg;

  typedef enum logic [1:0] {
    PmpModeOff   = 2'b00,
    PmpModeTor   = 2'b01,
    PmpModeNa4   = 2'b10,
    PmpModeNapot = 2'b11
  } pmp_cfg_mode_e;

  typedef struct packed {
    logic          lock;
    pmp_cfg_mode_e mode;
    logic          exec;
    logic          write;
    logic          read;
  } pmp_cfg_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } pmp_mseccfg_t;

  localparam logic [11:0] CSR_PMPCFG0   = 12'h3A0;
  localparam logic [11:0] CSR_PMPCFG1   = 12'h3A1;
  localparam logic [11:0] CSR_PMPCFG2   = 12'h3A2;
  localparam logic [11:0] CSR_PMPCFG3   = 12'h3A3;
  localparam logic [11:0] CSR_PMPADDR0  = 12'h3B0;
  localparam logic [11:0] CSR_PMPADDR1  = 12'h3B1;
  localparam logic [11:0] CSR_PMPADDR2  = 12'h3B2;
  localparam logic [11:0] CSR_PMPADDR3  = 12'h3B3;
  localparam logic [11:0] CSR_PMPADDR4  = 12'h3B4;
  localparam logic [11:0] CSR_PMPADDR5  = 12'h3B5;
  localparam logic [11:0] CSR_PMPADDR6  = 12'h3B6;
  localparam logic [11:0] CSR_PMPADDR7  = 12'h3B7;
  localparam logic [11:0] CSR_PMPADDR8  = 12'h3B8;
  localparam logic [11:0] CSR_PMPADDR9  = 12'h3B9;
  localparam logic [11:0] CSR_PMPADDR10 = 12'h3BA;
  localparam logic [11:0] CSR_PMPADDR11 = 12'h3BB;
  localparam logic [11:0] CSR_PMPADDR12 = 12'h3BC;
  localparam logic [11:0] CSR_PMPADDR13 = 12'h3BD;
  localparam logic [11:0] CSR_PMPADDR14 = 12'h3BE;
  localparam logic [11:0] CSR_PMPADDR15 = 12'h3BF;
  localparam logic [11:0] CSR_MSECCFG   = 12'h747;
  localparam logic [11:0] CSR_MSECCFGH  = 12'h757;

  // W without R is only a legal encoding once machine-mode lockdown is active.
  function automatic pmp_cfg_t pmp_cfg_legalise(logic [7:0] wdata, logic mml, int unsigned g);
    pmp_cfg_t cfg;
    cfg.lock  = wdata[7];
    cfg.mode  = pmp_cfg_mode_e'(wdata[4:3]);
    cfg.exec  = wdata[2];
    cfg.write = wdata[1];
    cfg.read  = wdata[0];
    if (!mml && cfg.write && !cfg.read) begin
      cfg.write = 1'b0;
    end
    if (g > 0 && cfg.mode == PmpModeNa4) begin
      cfg.mode = PmpModeOff;
    end
    return cfg;
  endfunction

  function automatic logic [7:0] pmp_cfg_rdata(pmp_cfg_t cfg);
    return {cfg.lock, 2'b00, cfg.mode, cfg.exec, cfg.write, cfg.read};
  endfunction

endpackage

// File: rtl/ibex_pmp_csr_entry.sv
// One PMP entry: cfg + address storage with lock gating.
// IBEX_PMP_SHADOW_EN adds bit-inverted shadow copies and a mismatch flag.
module ibex_pmp_csr_entry
  import ibex_pmp_csr_regs_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_we_i,
  input  pmp_cfg_t    cfg_wdata_i,
  input  logic        cfg_mml_drop_i,
  input  logic        addr_we_i,
  input  logic [31:0] addr_wdata_i,
  input  logic        rlb_i,
  input  logic        next_tor_locked_i,
  output pmp_cfg_t    cfg_o,
  output logic [31:0] addr_o,
  output logic        tor_locked_o,
  output logic        wr_dropped_o,
  output logic        shadow_err_o
);

  pmp_cfg_t    cfg_q;
  logic [31:0] addr_q;
  logic        locked;
  logic        cfg_upd;
  logic        addr_upd;

  assign locked   = cfg_q.lock & ~rlb_i;
  assign cfg_upd  = cfg_we_i & ~locked & ~cfg_mml_drop_i;
  // A locked TOR entry above also freezes this entry's address (its lower bound).
  assign addr_upd = addr_we_i & ~locked & ~next_tor_locked_i;

  assign wr_dropped_o = (cfg_we_i & ~cfg_upd) | (addr_we_i & ~addr_upd);
  assign tor_locked_o = locked & (cfg_q.mode == PmpModeTor);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_q  <= '0;
      addr_q <= '0;
    end else begin
      if (cfg_upd) cfg_q <= cfg_wdata_i;
      if (addr_upd) addr_q <= addr_wdata_i;
    end
  end

`ifdef IBEX_PMP_SHADOW_EN
  logic [$bits(pmp_cfg_t)-1:0] cfg_shadow_q;
  logic [31:0]                 addr_shadow_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_shadow_q  <= '1;
      addr_shadow_q <= '1;
    end else begin
      if (cfg_upd) cfg_shadow_q <= ~cfg_wdata_i;
      if (addr_upd) addr_shadow_q <= ~addr_wdata_i;
    end
  end

  assign shadow_err_o = (cfg_q != ~cfg_shadow_q) | (addr_q != ~addr_shadow_q);
`else
  assign shadow_err_o = 1'b0;
`endif

  assign cfg_o  = cfg_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/ibex_pmp_csr_regs.sv
// PMP CSR register file (pmpcfg0-3, pmpaddr0-15, mseccfg/h) feeding the PMP checker.
// Optional IBEX_PMP_SHADOW_EN: inverted shadow registers with a sticky pmp_alert_o.
module ibex_pmp_csr_regs
  import ibex_pmp_csr_regs_pkg::*;
#(
  parameter int unsigned PMPGranularity = 0,
  parameter int unsigned PMPNumRegions  = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         csr_we_i,
  input  logic [11:0]  csr_addr_i,
  input  logic [31:0]  csr_wdata_i,
  output logic         csr_addr_hit_o,
  output logic [31:0]  csr_rdata_o,
  output pmp_cfg_t     csr_pmp_cfg_o [PMPNumRegions],
  output logic [33:0]  csr_pmp_addr_o [PMPNumRegions],
  output pmp_mseccfg_t csr_pmp_mseccfg_o,
  output logic         pmp_wr_ignored_o,
  output logic         pmp_alert_o
);

  localparam logic [31:0] NapotMask =
      (PMPGranularity >= 2) ? (32'd1 << (PMPGranularity - 1)) - 32'd1 : 32'd0;
  localparam logic [31:0] TorMask =
      (PMPGranularity >= 1) ? (32'd1 << PMPGranularity) - 32'd1 : 32'd0;

  function automatic logic [31:0] addr_rdata(logic [31:0] addr, pmp_cfg_mode_e mode);
    if (mode == PmpModeNapot) return addr | NapotMask;
    if (mode == PmpModeOff || mode == PmpModeTor) return addr & ~TorMask;
    return addr;
  endfunction

  logic is_cfg, is_addr, is_msec, is_msech;
  assign is_cfg   = csr_addr_i[11:2] == CSR_PMPCFG0[11:2];
  assign is_addr  = csr_addr_i[11:4] == CSR_PMPADDR0[11:4];
  assign is_msec  = csr_addr_i == CSR_MSECCFG;
  assign is_msech = csr_addr_i == CSR_MSECCFGH;
  assign csr_addr_hit_o = is_cfg | is_addr | is_msec | is_msech;

  pmp_mseccfg_t             mseccfg_q, mseccfg_d;
  pmp_cfg_t                 cfg [PMPNumRegions];
  logic [31:0]              addr [PMPNumRegions];
  logic [PMPNumRegions-1:0] lock_bits, dropped, shadow_err;
  logic [PMPNumRegions:0]   tor_locked;
  logic                     rlb_ok, rlb_drop, wr_ignored_q;

  assign tor_locked[PMPNumRegions] = 1'b0;

  for (genvar i = 0; i < PMPNumRegions; i++) begin : gen_entry
    logic [7:0] wbyte;
    logic       mml_drop;
    assign wbyte    = csr_wdata_i[8*(i%4) +: 8];
    assign mml_drop = mseccfg_q.mml & ~mseccfg_q.rlb & wbyte[7] &
                      (wbyte[2] | (~wbyte[0] & wbyte[1]));

    ibex_pmp_csr_entry u_entry (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .cfg_we_i          (csr_we_i & is_cfg & (csr_addr_i[1:0] == 2'(i / 4))),
      .cfg_wdata_i       (pmp_cfg_legalise(wbyte, mseccfg_q.mml, PMPGranularity)),
      .cfg_mml_drop_i    (mml_drop),
      .addr_we_i         (csr_we_i & is_addr & (csr_addr_i[3:0] == 4'(i))),
      .addr_wdata_i      (csr_wdata_i),
      .rlb_i             (mseccfg_q.rlb),
      .next_tor_locked_i (tor_locked[i+1]),
      .cfg_o             (cfg[i]),
      .addr_o            (addr[i]),
      .tor_locked_o      (tor_locked[i]),
      .wr_dropped_o      (dropped[i]),
      .shadow_err_o      (shadow_err[i])
    );

    assign lock_bits[i]      = cfg[i].lock;
    assign csr_pmp_cfg_o[i]  = cfg[i];
    assign csr_pmp_addr_o[i] = {addr[i], 2'b00};
  end

  // Unimplemented entries read as zero.
  logic [7:0]  cfg_rd  [16];
  logic [31:0] addr_rd [16];
  for (genvar i = 0; i < 16; i++) begin : gen_rd
    if (i < PMPNumRegions) begin : gen_impl
      assign cfg_rd[i]  = pmp_cfg_rdata(cfg[i]);
      assign addr_rd[i] = addr_rdata(addr[i], cfg[i].mode);
    end else begin : gen_unimpl
      assign cfg_rd[i]  = '0;
      assign addr_rd[i] = '0;
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    if (is_cfg) begin
      csr_rdata_o = {cfg_rd[{csr_addr_i[1:0], 2'd3}], cfg_rd[{csr_addr_i[1:0], 2'd2}],
                     cfg_rd[{csr_addr_i[1:0], 2'd1}], cfg_rd[{csr_addr_i[1:0], 2'd0}]};
    end else if (is_addr) begin
      csr_rdata_o = addr_rd[csr_addr_i[3:0]];
    end else if (is_msec) begin
      csr_rdata_o = {29'b0, mseccfg_q};
    end
  end

  // mml/mmwp are sticky; rlb may only change while unlocked or already set.
  assign rlb_ok   = mseccfg_q.rlb | ~(|lock_bits);
  assign rlb_drop = csr_we_i & is_msec & ~rlb_ok & csr_wdata_i[2];

  always_comb begin
    mseccfg_d = mseccfg_q;
    if (csr_we_i && is_msec) begin
      mseccfg_d.mml  = mseccfg_q.mml | csr_wdata_i[0];
      mseccfg_d.mmwp = mseccfg_q.mmwp | csr_wdata_i[1];
      mseccfg_d.rlb  = rlb_ok ? csr_wdata_i[2] : mseccfg_q.rlb;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mseccfg_q    <= '0;
      wr_ignored_q <= 1'b0;
    end else begin
      mseccfg_q    <= mseccfg_d;
      wr_ignored_q <= (|dropped) | rlb_drop;
    end
  end

`ifdef IBEX_PMP_SHADOW_EN
  logic [2:0] mseccfg_shadow_q;
  logic       alert_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mseccfg_shadow_q <= '1;
      alert_q          <= 1'b0;
    end else begin
      mseccfg_shadow_q <= ~mseccfg_d;
      alert_q          <= alert_q | (|shadow_err) | (mseccfg_q != ~mseccfg_shadow_q);
    end
  end

  assign pmp_alert_o = alert_q;
`else
  logic unused_shadow_err;
  assign unused_shadow_err = ^shadow_err;
  assign pmp_alert_o       = 1'b0;
`endif

  assign csr_pmp_mseccfg_o = mseccfg_q;
  assign pmp_wr_ignored_o  = wr_ignored_q;

endmodule

// File: tb/tb_ibex_pmp_csr_regs.sv
// Directed bench for ibex_pmp_csr_regs at granularities 0, 1 and 3 driven in parallel.
module tb_ibex_pmp_csr_regs;
  import ibex_pmp_csr_regs_pkg::*;

  logic        clk, rst, we;
  logic [11:0] csr_addr;
  logic [31:0] wdata;

  logic         hit0, hit1, hit3, ign0, ign1, ign3, alert0, alert1, alert3;
  logic [31:0]  rdata0, rdata1, rdata3;
  pmp_cfg_t     cfg0 [4], cfg1 [4], cfg3 [4];
  logic [33:0]  addr0 [4], addr1 [4], addr3 [4];
  pmp_mseccfg_t ms0, ms1, ms3;

  int n_checks = 0;
  int n_errors = 0;

  ibex_pmp_csr_regs #(.PMPGranularity(0), .PMPNumRegions(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .csr_we_i(we), .csr_addr_i(csr_addr), .csr_wdata_i(wdata),
    .csr_addr_hit_o(hit0), .csr_rdata_o(rdata0), .csr_pmp_cfg_o(cfg0), .csr_pmp_addr_o(addr0),
    .csr_pmp_mseccfg_o(ms0), .pmp_wr_ignored_o(ign0), .pmp_alert_o(alert0)
  );
  ibex_pmp_csr_regs #(.PMPGranularity(1), .PMPNumRegions(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .csr_we_i(we), .csr_addr_i(csr_addr), .csr_wdata_i(wdata),
    .csr_addr_hit_o(hit1), .csr_rdata_o(rdata1), .csr_pmp_cfg_o(cfg1), .csr_pmp_addr_o(addr1),
    .csr_pmp_mseccfg_o(ms1), .pmp_wr_ignored_o(ign1), .pmp_alert_o(alert1)
  );
  ibex_pmp_csr_regs #(.PMPGranularity(3), .PMPNumRegions(4)) dut3 (
    .clk_i(clk), .rst_i(rst), .csr_we_i(we), .csr_addr_i(csr_addr), .csr_wdata_i(wdata),
    .csr_addr_hit_o(hit3), .csr_rdata_o(rdata3), .csr_pmp_cfg_o(cfg3), .csr_pmp_addr_o(addr3),
    .csr_pmp_mseccfg_o(ms3), .pmp_wr_ignored_o(ign3), .pmp_alert_o(alert3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; csr_addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a);
    @(negedge clk);
    csr_addr = a;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; csr_addr = 12'h3A0; wdata = '0;
    #1 rst = 1'b1;
    #2;
    check_eq("rst_cfg0", 64'(cfg0[0]), 64'h0);
    check_eq("rst_addr0", 64'(addr0[0]), 64'h0);
    check_eq("rst_mseccfg", 64'(ms0), 64'h0);
    check_eq("rst_ignored", 64'(ign0), 64'h0);
    check_eq("rst_alert", 64'(alert0), 64'h0);
    check_eq("rst_rdata", 64'(rdata0), 64'h0);
    check_eq("rst_hit", 64'(hit0), 64'h1);
    @(negedge clk);
    rst = 1'b0;

    // basic cfg write: byte0 TOR+RWX, byte1 NAPOT+RWX
    wr(12'h3A0, 32'h0000_1F0F);
    check_eq("cfg_wr_ign", 64'(ign0), 64'h0);
    check_eq("cfg0_tor", 64'(cfg0[0]), 64'h0F);
    check_eq("cfg1_napot", 64'(cfg1[1]), 64'h1F);
    rd(12'h3A0);
    check_eq("cfg_read", 64'(rdata0), 64'h1F0F);

    // lock entry 1 as TOR; pmpaddr0 and pmpaddr1 become read-only
    wr(12'h3A0, 32'h0000_8F0F);
    check_eq("lock_cfg1", 64'(cfg0[1]), 64'h2F);
    check_eq("lock_wr_ign", 64'(ign0), 64'h0);
    wr(12'h3B0, 32'h1234);
    check_eq("addr0_tor_pulse", 64'(ign0), 64'h1);
    wr(12'h3B1, 32'h5678);
    check_eq("addr1_lock_pulse", 64'(ign0), 64'h1);
    @(negedge clk);
    check_eq("pulse_ends", 64'(ign0), 64'h0);
    check_eq("addr0_kept", 64'(addr0[0]), 64'h0);
    check_eq("addr1_kept", 64'(addr0[1]), 64'h0);
    wr(12'h3B2, 32'hABC);
    check_eq("addr2_ok_ign", 64'(ign0), 64'h0);
    check_eq("addr2_out", 64'(addr0[2]), 64'h2AF0);
    rd(12'h3B2);
    check_eq("addr2_read", 64'(rdata0), 64'hABC);

    // W without R cleared; locked byte1 dropped in the same write
    wr(12'h3A0, 32'h0000_8F0A);
    check_eq("partial_pulse", 64'(ign0), 64'h1);
    rd(12'h3A0);
    check_eq("warl_w_only", 64'(rdata0), 64'h8F08);

    // unimplemented entries, mseccfgh and misses
    wr(12'h3A1, 32'hFFFF_FFFF);
    check_eq("unimpl_cfg_ign", 64'(ign0), 64'h0);
    rd(12'h3A1);
    check_eq("unimpl_cfg_rd", 64'(rdata0), 64'h0);
    check_eq("unimpl_cfg_hit", 64'(hit0), 64'h1);
    wr(12'h3B5, 32'hFFFF);
    check_eq("unimpl_addr_ign", 64'(ign0), 64'h0);
    rd(12'h3B5);
    check_eq("unimpl_addr_rd", 64'(rdata0), 64'h0);
    check_eq("unimpl_addr_hit", 64'(hit0), 64'h1);
    wr(12'h757, 32'hFFFF_FFFF);
    check_eq("mseccfgh_ign", 64'(ign0), 64'h0);
    check_eq("mseccfgh_no_eff", 64'(ms0), 64'h0);
    rd(12'h757);
    check_eq("mseccfgh_rd", 64'(rdata0), 64'h0);
    check_eq("mseccfgh_hit", 64'(hit0), 64'h1);
    wr(12'h300, 32'hFF);
    check_eq("miss_ign", 64'(ign0), 64'h0);
    rd(12'h300);
    check_eq("miss_hit", 64'(hit0), 64'h0);
    check_eq("miss_rd", 64'(rdata0), 64'h0);

    // NA4 unavailable once G > 0
    wr(12'h3A0, 32'h0000_8F10);
    rd(12'h3A0);
    check_eq("na4_g0", 64'(rdata0), 64'h8F10);
    check_eq("na4_g1_off", 64'(rdata1), 64'h8F00);
    check_eq("na4_g1_cfg", 64'(cfg1[0]), 64'h0);

    // pmpaddr read masking by granularity and mode
    wr(12'h3A0, 32'h0018_8F18);
    wr(12'h3B2, 32'h100);
    rd(12'h3B2);
    check_eq("napot_g3", 64'(rdata3), 64'h103);
    check_eq("napot_g1", 64'(rdata1), 64'h100);
    check_eq("napot_g0", 64'(rdata0), 64'h100);
    check_eq("napot_g3_store", 64'(addr3[2]), 64'h400);
    wr(12'h3A0, 32'h0000_8F18);
    rd(12'h3B2);
    check_eq("off_g3", 64'(rdata3), 64'h100);
    wr(12'h3B3, 32'h101);
    rd(12'h3B3);
    check_eq("off_g1_lsb", 64'(rdata1), 64'h100);
    check_eq("off_g0_lsb", 64'(rdata0), 64'h101);
    check_eq("off_g3_lsb", 64'(rdata3), 64'h100);

    // rlb refused while an entry is locked; mml/mmwp sticky
    do_reset();
    wr(12'h3A0, 32'h80);
    wr(12'h747, 32'h4);
    check_eq("rlb_deny_pulse", 64'(ign0), 64'h1);
    check_eq("rlb_deny_val", 64'(ms0), 64'h0);
    wr(12'h747, 32'h3);
    check_eq("msec_set_ign", 64'(ign0), 64'h0);
    wr(12'h747, 32'h0);
    rd(12'h747);
    check_eq("msec_sticky_rd", 64'(rdata0), 64'h3);
    check_eq("msec_sticky_out", 64'(ms0), 64'h3);

    // mml: locked executable byte dropped, locked read-only byte accepted
    do_reset();
    wr(12'h747, 32'h1);
    wr(12'h3A0, 32'h0000_8C00);
    check_eq("mml_drop_pulse", 64'(ign0), 64'h1);
    rd(12'h3A0);
    check_eq("mml_drop_rd", 64'(rdata0), 64'h0);
    wr(12'h3A0, 32'h0000_8900);
    check_eq("mml_ok_ign", 64'(ign0), 64'h0);
    rd(12'h3A0);
    check_eq("mml_ok_rd", 64'(rdata0), 64'h8900);

    // rlb set from reset bypasses locks until cleared
    do_reset();
    wr(12'h747, 32'h4);
    check_eq("rlb_set", 64'(ms0), 64'h4);
    wr(12'h3A0, 32'h81);
    check_eq("rlb_cfg_ign", 64'(ign0), 64'h0);
    wr(12'h3B0, 32'h55);
    check_eq("rlb_addr_ign", 64'(ign0), 64'h0);
    rd(12'h3B0);
    check_eq("rlb_addr_rd", 64'(rdata0), 64'h55);
    wr(12'h747, 32'h0);
    check_eq("rlb_clear", 64'(ms0), 64'h0);
    wr(12'h3B0, 32'h66);
    check_eq("relock_pulse", 64'(ign0), 64'h1);
    rd(12'h3B0);
    check_eq("relock_rd", 64'(rdata0), 64'h55);

    // asynchronous reset in the middle of a write
    @(negedge clk);
    we = 1'b1; csr_addr = 12'h3B2; wdata = 32'h77;
    #2 rst = 1'b1;
    #1;
    check_eq("async_addr0", 64'(addr0[0]), 64'h0);
    check_eq("async_cfg0", 64'(cfg0[0]), 64'h0);
    check_eq("async_ign", 64'(ign0), 64'h0);
    @(negedge clk);
    we = 1'b0; rst = 1'b0;
    rd(12'h3B2);
    check_eq("async_wr_lost", 64'(rdata0), 64'h0);
    check_eq("alert_idle", 64'(alert0), 64'h0);

`ifdef IBEX_PMP_SHADOW_EN
    @(negedge clk);
    force dut0.gen_entry[0].u_entry.addr_shadow_q = 32'h0;
    #1;
    check_eq("alert_not_yet", 64'(alert0), 64'h0);
    @(negedge clk);
    check_eq("alert_set", 64'(alert0), 64'h1);
    release dut0.gen_entry[0].u_entry.addr_shadow_q;
    repeat (3) @(negedge clk);
    check_eq("alert_hold", 64'(alert0), 64'h1);
    rst = 1'b1;
    #1;
    check_eq("alert_rst", 64'(alert0), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("alert_clean", 64'(alert0), 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
